// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared types, constants and 7-segment decode for lap_stopwatch
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    localparam int c_BCD_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // Active-low segments, bit 0 = a ... bit 6 = g; non-decimal codes blank.
    function automatic logic [6:0] seg_encode(input logic [c_BCD_WIDTH-1:0] i_digit);
        logic [6:0] w_seg;
        case (i_digit)
            4'd0:    w_seg = 7'b1000000;
            4'd1:    w_seg = 7'b1111001;
            4'd2:    w_seg = 7'b0100100;
            4'd3:    w_seg = 7'b0110000;
            4'd4:    w_seg = 7'b0011001;
            4'd5:    w_seg = 7'b0010010;
            4'd6:    w_seg = 7'b0000010;
            4'd7:    w_seg = 7'b1111000;
            4'd8:    w_seg = 7'b0000000;
            4'd9:    w_seg = 7'b0010000;
            default: w_seg = 7'b1111111;
        endcase
        return w_seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_filter.sv
`default_nettype none
// ============================================================================
// Module      : debounce_filter
// Description : Switch filter; output follows input after DEBOUNCE_TIME stable cycles
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_filter #(
    parameter int DEBOUNCE_TIME = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    output logic o_Switch
);

    localparam int              c_CW      = $clog2(DEBOUNCE_TIME + 1);
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(DEBOUNCE_TIME - 1);

    logic [c_CW-1:0] r_count_q;
    logic [c_CW-1:0] w_count_d;
    logic            r_level_q;
    logic            w_level_d;

    // Any return to the current level restarts the stability window.
    always_comb begin
        w_count_d = '0;
        w_level_d = r_level_q;
        if ((i_Switch != r_level_q) && (r_count_q < c_CNT_MAX)) begin
            w_count_d = r_count_q + c_CW'(1);
        end else if (r_count_q == c_CNT_MAX) begin
            w_level_d = i_Switch;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_count_q <= '0;
            r_level_q <= 1'b0;
        end else begin
            r_count_q <= w_count_d;
            r_level_q <= w_level_d;
        end
    end

    assign o_Switch = r_level_q;

endmodule
`default_nettype wire

// File: rtl/lap_stopwatch.sv
`default_nettype none
// ============================================================================
// Module      : lap_stopwatch
// Description : BCD centisecond stopwatch with start/stop, lap and reset
// Revision    : 1.0 - initial release
// ============================================================================
module lap_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int CENTISECOND   = 250000,
    parameter int DEBOUNCE_TIME = 250000
) (
    input  logic                              i_Clk,
    input  logic                              i_Rst,
    input  logic                              i_Switch_1,
    input  logic                              i_Switch_2,
    output logic [c_BCD_WIDTH*NUM_DIGITS-1:0] o_Bcd,
    output logic [6:0]                        o_Segments1,
    output logic [6:0]                        o_Segments2,
    output logic                              o_Running,
    output logic                              o_Lap,
    output logic                              o_Wrap
);

    localparam int              c_W          = c_BCD_WIDTH * NUM_DIGITS;
    localparam int              c_PW         = $clog2(CENTISECOND);
    localparam logic [c_PW-1:0] c_PRESC_MAX  = c_PW'(CENTISECOND - 1);

    logic            w_sw1_deb;
    logic            w_sw2_deb;
    logic            r_sw1_prev_q;
    logic            r_sw2_prev_q;
    logic            w_start;
    logic            w_lap_press;
    logic            w_tick;
    state_t          r_state_q;
    state_t          w_state_d;
    logic [c_PW-1:0] r_presc_q;
    logic [c_PW-1:0] w_presc_d;
    logic [c_W-1:0]  r_count_q;
    logic [c_W-1:0]  w_count_d;
    logic [c_W-1:0]  w_count_inc;
    logic [NUM_DIGITS:0] w_carry;
    logic            r_lap_q;
    logic            w_lap_d;
    logic [c_W-1:0]  r_lap_val_q;
    logic [c_W-1:0]  w_lap_val_d;
    logic            r_wrap_q;
    logic            w_wrap_d;
    logic [c_W-1:0]  w_display;
    logic [6:0]      r_seg1_q;
    logic [6:0]      r_seg2_q;

    debounce_filter #(.DEBOUNCE_TIME(DEBOUNCE_TIME)) u_debounce_start (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_Switch (i_Switch_1),
        .o_Switch (w_sw1_deb)
    );

    debounce_filter #(.DEBOUNCE_TIME(DEBOUNCE_TIME)) u_debounce_lap (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_Switch (i_Switch_2),
        .o_Switch (w_sw2_deb)
    );

    assign w_start     = w_sw1_deb & ~r_sw1_prev_q;
    assign w_lap_press = w_sw2_deb & ~r_sw2_prev_q;
    assign w_tick      = (r_state_q == RUN) && (r_presc_q == c_PRESC_MAX);

    // Ripple-carry BCD increment; the carry out of the top digit is the wrap.
    assign w_carry[0] = w_tick;
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        logic [c_BCD_WIDTH-1:0] w_digit;
        logic                   w_is_nine;
        assign w_digit   = r_count_q[g*c_BCD_WIDTH +: c_BCD_WIDTH];
        assign w_is_nine = (w_digit == 4'd9);
        assign w_count_inc[g*c_BCD_WIDTH +: c_BCD_WIDTH] =
            !w_carry[g] ? w_digit : (w_is_nine ? 4'd0 : w_digit + 4'd1);
        assign w_carry[g+1] = w_carry[g] & w_is_nine;
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_presc_d   = r_presc_q;
        w_count_d   = w_count_inc;
        w_lap_d     = r_lap_q;
        w_lap_val_d = r_lap_val_q;
        w_wrap_d    = w_carry[NUM_DIGITS];

        if (r_state_q == RUN) begin
            w_presc_d = w_tick ? '0 : r_presc_q + c_PW'(1);
        end else if (r_state_q == IDLE) begin
            w_presc_d = '0;
        end

        // Start/stop wins over a lap/reset press in the same cycle.
        if (w_start) begin
            case (r_state_q)
                IDLE:    w_state_d = RUN;
                RUN:     w_state_d = PAUSE;
                PAUSE:   w_state_d = RUN;
                default: w_state_d = IDLE;
            endcase
        end else if (w_lap_press) begin
            case (r_state_q)
                RUN: begin
                    if (r_lap_q) begin
                        w_lap_d = 1'b0;
                    end else begin
                        w_lap_val_d = r_count_q;
                        w_lap_d     = 1'b1;
                    end
                end
                PAUSE: begin
                    if (r_lap_q) begin
                        w_lap_d = 1'b0;
                    end else begin
                        w_count_d = '0;
                        w_presc_d = '0;
                        w_state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state_q    <= IDLE;
            r_presc_q    <= '0;
            r_count_q    <= '0;
            r_lap_q      <= 1'b0;
            r_lap_val_q  <= '0;
            r_wrap_q     <= 1'b0;
            r_sw1_prev_q <= 1'b0;
            r_sw2_prev_q <= 1'b0;
            r_seg1_q     <= seg_encode(4'd0);
            r_seg2_q     <= seg_encode(4'd0);
        end else begin
            r_state_q    <= w_state_d;
            r_presc_q    <= w_presc_d;
            r_count_q    <= w_count_d;
            r_lap_q      <= w_lap_d;
            r_lap_val_q  <= w_lap_val_d;
            r_wrap_q     <= w_wrap_d;
            r_sw1_prev_q <= w_sw1_deb;
            r_sw2_prev_q <= w_sw2_deb;
            r_seg1_q     <= seg_encode(w_display[c_BCD_WIDTH +: c_BCD_WIDTH]);
            r_seg2_q     <= seg_encode(w_display[0 +: c_BCD_WIDTH]);
        end
    end

    assign w_display   = r_lap_q ? r_lap_val_q : r_count_q;
    assign o_Bcd       = w_display;
    assign o_Segments1 = r_seg1_q;
    assign o_Segments2 = r_seg2_q;
    assign o_Running   = (r_state_q == RUN);
    assign o_Lap       = r_lap_q;
    assign o_Wrap      = r_wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_lap_stopwatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_lap_stopwatch
// Description : Self-checking bench: scenario table, wrap sequence, random presses
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lap_stopwatch;

    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2;
    localparam int OP_NONE = 0, OP_START = 1, OP_LAP = 2, OP_BOTH = 3, OP_RST = 4;
    localparam int M_EQ = 0, M_GE = 1, M_SNAP_EQ = 2, M_SNAP_GT = 3;

    typedef struct {
        int op;
        int wait_cyc;
        int exp_run;
        int exp_lap;
        int mode;
        int val;
        int snap;
    } step_t;

    typedef logic [48:0] vec_t;

    logic        clk = 1'b0;
    logic        a_rst, a_sw1, a_sw2, b_rst, b_sw1, b_sw2;
    logic [11:0] a_bcd;
    logic [7:0]  b_bcd;
    logic [6:0]  a_seg1, a_seg2, b_seg1, b_seg2;
    logic        a_run, a_lap, a_wrap, b_run, b_lap, b_wrap;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    logic [6:0] c_SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int p_cs  [2] = '{100, 3};
    int p_dt  [2] = '{50, 2};
    int p_mod [2] = '{1000, 100};
    int p_nd  [2] = '{3, 2};

    // Reference model state, one slot per DUT instance
    int         m_st   [2];
    int         m_ps   [2];
    int         m_cnt  [2];
    int         m_lapv [2];
    bit         m_lap  [2];
    bit         m_wrap [2];
    bit         m_deb  [2][2];
    bit         m_prev [2][2];
    int         m_stab [2][2];
    logic [6:0] m_seg1 [2];
    logic [6:0] m_seg2 [2];

    always #5 clk = ~clk;

    lap_stopwatch #(.NUM_DIGITS(3), .CENTISECOND(100), .DEBOUNCE_TIME(50)) u_dut_a (
        .i_Clk(clk), .i_Rst(a_rst), .i_Switch_1(a_sw1), .i_Switch_2(a_sw2),
        .o_Bcd(a_bcd), .o_Segments1(a_seg1), .o_Segments2(a_seg2),
        .o_Running(a_run), .o_Lap(a_lap), .o_Wrap(a_wrap)
    );

    lap_stopwatch #(.NUM_DIGITS(2), .CENTISECOND(3), .DEBOUNCE_TIME(2)) u_dut_b (
        .i_Clk(clk), .i_Rst(b_rst), .i_Switch_1(b_sw1), .i_Switch_2(b_sw2),
        .o_Bcd(b_bcd), .o_Segments1(b_seg1), .o_Segments2(b_seg2),
        .o_Running(b_run), .o_Lap(b_lap), .o_Wrap(b_wrap)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void model_step(int k, bit rst, bit r1, bit r2);
        int disp;
        int old_cnt;
        bit tick;
        bit [1:0] press;
        bit [1:0] raw;
        raw = {r2, r1};
        if (rst) begin
            m_st[k] = S_IDLE; m_ps[k] = 0; m_cnt[k] = 0; m_lapv[k] = 0;
            m_lap[k] = 1'b0; m_wrap[k] = 1'b0;
            m_seg1[k] = c_SEG[0]; m_seg2[k] = c_SEG[0];
            for (int s = 0; s < 2; s++) begin
                m_deb[k][s] = 1'b0; m_prev[k][s] = 1'b0; m_stab[k][s] = 0;
            end
            return;
        end
        disp = m_lap[k] ? m_lapv[k] : m_cnt[k];
        m_seg1[k] = c_SEG[(disp / 10) % 10];
        m_seg2[k] = c_SEG[disp % 10];
        for (int s = 0; s < 2; s++) press[s] = m_deb[k][s] && !m_prev[k][s];
        tick    = (m_st[k] == S_RUN) && (m_ps[k] == p_cs[k] - 1);
        old_cnt = m_cnt[k];
        m_wrap[k] = tick && (old_cnt == p_mod[k] - 1);
        if (tick) m_cnt[k] = (old_cnt + 1) % p_mod[k];
        if (m_st[k] == S_RUN) m_ps[k] = tick ? 0 : m_ps[k] + 1;
        else if (m_st[k] == S_IDLE) m_ps[k] = 0;
        if (press[0]) begin
            m_st[k] = (m_st[k] == S_RUN) ? S_PAUSE : S_RUN;
        end else if (press[1]) begin
            if (m_st[k] == S_RUN) begin
                if (m_lap[k]) m_lap[k] = 1'b0;
                else begin m_lapv[k] = old_cnt; m_lap[k] = 1'b1; end
            end else if (m_st[k] == S_PAUSE) begin
                if (m_lap[k]) m_lap[k] = 1'b0;
                else begin m_cnt[k] = 0; m_ps[k] = 0; m_st[k] = S_IDLE; end
            end
        end
        for (int s = 0; s < 2; s++) begin
            m_prev[k][s] = m_deb[k][s];
            if (raw[s] != m_deb[k][s]) begin
                m_stab[k][s]++;
                if (m_stab[k][s] >= p_dt[k]) begin
                    m_deb[k][s]  = raw[s];
                    m_stab[k][s] = 0;
                end
            end else begin
                m_stab[k][s] = 0;
            end
        end
    endfunction

    function automatic vec_t exp_vec(int k);
        int d;
        int p;
        logic [31:0] b;
        b = '0;
        p = 1;
        d = m_lap[k] ? m_lapv[k] : m_cnt[k];
        for (int i = 0; i < p_nd[k]; i++) begin
            b[i*4 +: 4] = 4'((d / p) % 10);
            p = p * 10;
        end
        return {b, m_seg1[k], m_seg2[k], m_st[k] == S_RUN, m_lap[k], m_wrap[k]};
    endfunction

    function automatic int bcd_to_int(input logic [11:0] b);
        return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    always @(posedge clk) begin
        model_step(0, a_rst, a_sw1, a_sw2);
        model_step(1, b_rst, b_sw1, b_sw2);
    end

    always @(negedge clk) begin
        if (chk_en && n_fail < 200) begin
            check("cycle_a", {32'(a_bcd), a_seg1, a_seg2, a_run, a_lap, a_wrap}, exp_vec(0));
            check("cycle_b", {32'(b_bcd), b_seg1, b_seg2, b_run, b_lap, b_wrap}, exp_vec(1));
        end
    end

    // Bouncing press: four 3-cycle bounces, 70-cycle hold, 70-cycle release
    task automatic press_a(input bit s1, input bit s2);
        for (int t = 0; t < 4; t++) begin
            a_sw1 = s1 & (t % 2 == 0);
            a_sw2 = s2 & (t % 2 == 0);
            repeat (3) @(negedge clk);
        end
        a_sw1 = s1; a_sw2 = s2;
        repeat (70) @(negedge clk);
        a_sw1 = 1'b0; a_sw2 = 1'b0;
        repeat (70) @(negedge clk);
    endtask

    step_t steps [15];
    int    snap;
    int    val;
    int    n;
    bit    digits_ok;

    initial begin
        steps[0]  = '{OP_NONE,  10,  0, 0, M_EQ,      0, 0};
        steps[1]  = '{OP_START, 550, 1, 0, M_GE,      5, 0};
        steps[2]  = '{OP_LAP,   0,   1, 1, M_GE,      5, 1};
        steps[3]  = '{OP_NONE,  500, 1, 1, M_SNAP_EQ, 0, 0};
        steps[4]  = '{OP_LAP,   0,   1, 0, M_SNAP_GT, 4, 0};
        steps[5]  = '{OP_START, 0,   0, 0, M_GE,      5, 1};
        steps[6]  = '{OP_NONE,  550, 0, 0, M_SNAP_EQ, 0, 0};
        steps[7]  = '{OP_LAP,   0,   0, 0, M_EQ,      0, 0};
        steps[8]  = '{OP_NONE,  330, 0, 0, M_EQ,      0, 0};
        steps[9]  = '{OP_START, 300, 1, 0, M_GE,      2, 0};
        steps[10] = '{OP_BOTH,  0,   0, 0, M_GE,      2, 0};
        steps[11] = '{OP_BOTH,  0,   1, 0, M_GE,      2, 0};
        steps[12] = '{OP_LAP,   0,   1, 1, M_GE,      2, 0};
        steps[13] = '{OP_RST,   0,   0, 0, M_EQ,      0, 0};
        steps[14] = '{OP_NONE,  300, 0, 0, M_EQ,      0, 0};

        a_rst = 1'b1; b_rst = 1'b1;
        a_sw1 = 1'b0; a_sw2 = 1'b0; b_sw1 = 1'b0; b_sw2 = 1'b0;
        snap = 0;
        repeat (3) @(negedge clk);
        a_rst = 1'b0; b_rst = 1'b0;
        chk_en = 1'b1;

        for (int i = 0; i < 15; i++) begin
            case (steps[i].op)
                OP_START: press_a(1'b1, 1'b0);
                OP_LAP:   press_a(1'b0, 1'b1);
                OP_BOTH:  press_a(1'b1, 1'b1);
                OP_RST: begin
                    a_rst = 1'b1;
                    @(negedge clk);
                end
                default: ;
            endcase
            repeat (steps[i].wait_cyc) @(negedge clk);
            val = bcd_to_int(a_bcd);
            check($sformatf("step%0d_running", i), 64'(a_run), 64'(steps[i].exp_run));
            check($sformatf("step%0d_lap", i), 64'(a_lap), 64'(steps[i].exp_lap));
            digits_ok = (a_bcd[3:0] <= 4'd9) && (a_bcd[7:4] <= 4'd9) && (a_bcd[11:8] <= 4'd9);
            check($sformatf("step%0d_digits_le9", i), 64'(digits_ok), 64'd1);
            case (steps[i].mode)
                M_EQ:      check($sformatf("step%0d_bcd_eq", i), 64'(val), 64'(steps[i].val));
                M_GE:      check($sformatf("step%0d_bcd_ge_%0d val=%0d", i, steps[i].val, val),
                                 64'(val >= steps[i].val), 64'd1);
                M_SNAP_EQ: check($sformatf("step%0d_bcd_frozen", i), 64'(val), 64'(snap));
                default:   check($sformatf("step%0d_bcd_gt_%0d val=%0d", i, snap + steps[i].val, val),
                                 64'(val > snap + steps[i].val), 64'd1);
            endcase
            if (steps[i].mode == M_EQ && steps[i].val == 0) begin
                check($sformatf("step%0d_seg1_zero", i), 64'(a_seg1), 64'h40);
                check($sformatf("step%0d_seg2_zero", i), 64'(a_seg2), 64'h40);
            end
            if (steps[i].snap != 0) snap = val;
            if (steps[i].op == OP_RST) a_rst = 1'b0;
        end

        // Wrap from 99 to 00 on the small instance
        b_sw1 = 1'b1;
        repeat (4) @(negedge clk);
        b_sw1 = 1'b0;
        repeat (4) @(negedge clk);
        check("b_running_after_start", 64'(b_run), 64'd1);
        n = 0;
        while (b_bcd !== 8'h99 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("b_reach_99", 64'(b_bcd), 64'h99);
        check("b_wrap_low_at_99", 64'(b_wrap), 64'd0);
        n = 0;
        while (b_bcd === 8'h99 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("b_after_99_is_00", 64'(b_bcd), 64'h00);
        check("b_wrap_pulse", 64'(b_wrap), 64'd1);
        @(negedge clk);
        check("b_wrap_one_cycle", 64'(b_wrap), 64'd0);
        check("b_keeps_running", 64'(b_run), 64'd1);

        // Random bouncing buttons and occasional resets on both instances
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if ($urandom_range(79) == 0) a_sw1 = ~a_sw1;
            if ($urandom_range(69) == 0) a_sw2 = ~a_sw2;
            a_rst = ($urandom_range(7999) == 0);
            if ($urandom_range(11) == 0) b_sw1 = ~b_sw1;
            if ($urandom_range(9) == 0)  b_sw2 = ~b_sw2;
            b_rst = ($urandom_range(1999) == 0);
        end
        a_rst = 1'b0; b_rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
